pipe_hazard_ctrl: RTL

// Parametrised hazard/forwarding controller for the in-order pipeline (IF/ID/EX/MEM/WB and deeper variants).

---
 rtl/pipe_hazard_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - hazard, stall, flush and operand-forwarding control for the in-order pipeline
module pipe_hazard_ctrl #(
   parameter int REG_AW     = 3,
   parameter int FWD_STAGES = 2,
   parameter int LOAD_LAT   = 1,
   parameter bit ZERO_REG   = 1'b0,
   localparam int FW        = $clog2(FWD_STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic              id_rs1_used,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic              id_halt,
   input  logic              ex_redirect,
   output logic              stall,
   output logic              ex_bubble,
   output logic              flush_if_id,
   output logic [FW-1:0]     fwd_sel_a,
   output logic [FW-1:0]     fwd_sel_b,
   output logic              halted
);

   // First stage (counted from EX = 0, MEM = 1) at which load data can be forwarded
   localparam int LRS = 1 + LOAD_LAT;

   // Halt sequencing: a halt freezes issue immediately, and is reported once it drains out
   typedef enum logic [1:0] {
      HS_RUN    = 2'd0,
      HS_PEND   = 2'd1,
      HS_HALTED = 2'd2
   } halt_state_t;

   halt_state_t halt_state, halt_state_nxt;

   // In-flight writer tracker: index 0 is EX, index k is k stages past EX
   logic [FWD_STAGES:0]             e_v;
   logic [FWD_STAGES:0]             e_we;
   logic [FWD_STAGES:0]             e_ld;
   logic [FWD_STAGES:0]             e_hlt;
   logic [FWD_STAGES:0][REG_AW-1:0] e_rd;

   logic              halt_pend;
   logic              halt_retire;
   logic              issue;
   logic              haz_a, haz_b;
   logic [FW-1:0]     sel_a, sel_b;
   logic [FW:0]       res_a, res_b;

   // Resolve one operand against the tracker. Result is {hazard, select}.
   // The youngest (lowest index) matching writer wins. A writer that will already
   // have written back when the consumer reaches EX is served by the register file.
   function automatic logic [FW:0] resolve(
      input logic [REG_AW-1:0]             r,
      input logic                          used,
      input logic [FWD_STAGES:0]           v,
      input logic [FWD_STAGES:0]           we,
      input logic [FWD_STAGES:0]           ld,
      input logic [FWD_STAGES:0][REG_AW-1:0] rd
   );
      logic [FW:0] res;
      logic        found;
      res   = '0;
      found = 1'b0;
      for (int j = 0; j <= FWD_STAGES; j++) begin
         if (!found && used && v[j] && we[j] && (rd[j] == r) &&
             !(ZERO_REG && (r == '0))) begin
            found = 1'b1;
            if (j + 1 > FWD_STAGES) begin
               res = '0;
            end else if (ld[j] && (j + 1 < LRS)) begin
               res = {1'b1, {FW{1'b0}}};
            end else begin
               res = {1'b0, FW'(j + 1)};
            end
         end
      end
      return res;
   endfunction

   // Operand dependency resolution for the instruction currently in ID
   always_comb begin
      res_a = resolve(id_rs1, id_rs1_used, e_v, e_we, e_ld, e_rd);
      res_b = resolve(id_rs2, id_rs2_used, e_v, e_we, e_ld, e_rd);
      haz_a = res_a[FW];
      haz_b = res_b[FW];
      sel_a = res_a[FW-1:0];
      sel_b = res_b[FW-1:0];
   end

   assign halt_pend   = (halt_state != HS_RUN);
   assign halt_retire = e_v[FWD_STAGES] & e_hlt[FWD_STAGES];
   assign halted      = (halt_state == HS_HALTED);

   // Pipeline control: a redirect discards the ID instruction and overrides any stall
   always_comb begin
      stall       = (((haz_a | haz_b) & id_valid) | halt_pend) & ~ex_redirect;
      ex_bubble   = stall | ex_redirect;
      flush_if_id = ex_redirect;
      issue       = id_valid & ~stall & ~ex_redirect & ~halt_pend;
   end

   // Halt state next-state logic
   always_comb begin
      halt_state_nxt = halt_state;
      case (halt_state)
         HS_RUN:    if (issue && id_halt) halt_state_nxt = HS_PEND;
         HS_PEND:   if (halt_retire)      halt_state_nxt = HS_HALTED;
         HS_HALTED: halt_state_nxt = HS_HALTED;
         default:   halt_state_nxt = HS_RUN;
      endcase
   end

   // Halt state register
   always_ff @(posedge clk) begin
      if (rst) begin
         halt_state <= HS_RUN;
      end else begin
         halt_state <= halt_state_nxt;
      end
   end

   // Tracker shift: every entry advances each cycle, EX is refilled only on issue
   always_ff @(posedge clk) begin
      if (rst) begin
         e_v   <= '0;
         e_we  <= '0;
         e_ld  <= '0;
         e_hlt <= '0;
         e_rd  <= '0;
      end else begin
         e_v   <= {e_v[FWD_STAGES-1:0],   issue};
         e_we  <= {e_we[FWD_STAGES-1:0],  issue & id_we};
         e_ld  <= {e_ld[FWD_STAGES-1:0],  issue & id_is_load};
         e_hlt <= {e_hlt[FWD_STAGES-1:0], issue & id_halt};
         e_rd  <= {e_rd[FWD_STAGES-1:0],  id_rd};
      end
   end

   // Forwarding selects for the instruction entering EX; a bubble reads the register file
   always_ff @(posedge clk) begin
      if (rst) begin
         fwd_sel_a <= '0;
         fwd_sel_b <= '0;
      end else if (issue) begin
         fwd_sel_a <= sel_a;
         fwd_sel_b <= sel_b;
      end else begin
         fwd_sel_a <= '0;
         fwd_sel_b <= '0;
      end
   end

endmodule
